// File: rtl/me_pkg.sv
// Shared types and constants for the motion estimator control path.
package me_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        PRESENT,
        DONE
    } me_seq_state_t;

    localparam int unsigned ME_DEFAULT_CYCLES = 4112;
    localparam int unsigned BLK_IDX_W         = 4;
    localparam int unsigned MV_W              = 4;

endpackage

// File: rtl/me_blk_walker.sv
// Raster-order macroblock index counter: clear to (0,0), advance one block per request.
module me_blk_walker
    import me_pkg::*;
#(
    parameter int unsigned BLOCKS_X = 4,
    parameter int unsigned BLOCKS_Y = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 advance,
    output logic [BLK_IDX_W-1:0] blk_x,
    output logic [BLK_IDX_W-1:0] blk_y,
    output logic                 last
);

    localparam logic [BLK_IDX_W-1:0] XMax = BLK_IDX_W'(BLOCKS_X - 1);
    localparam logic [BLK_IDX_W-1:0] YMax = BLK_IDX_W'(BLOCKS_Y - 1);

    logic [BLK_IDX_W-1:0] blk_x_q;
    logic [BLK_IDX_W-1:0] blk_y_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            blk_x_q <= '0;
            blk_y_q <= '0;
        end else if (advance) begin
            if (blk_x_q == XMax) begin
                blk_x_q <= '0;
                // Advancing past the last block wraps the whole frame.
                blk_y_q <= (blk_y_q == YMax) ? '0 : blk_y_q + 1'b1;
            end else begin
                blk_x_q <= blk_x_q + 1'b1;
            end
        end
    end

    assign blk_x = blk_x_q;
    assign blk_y = blk_y_q;
    assign last  = (blk_x_q == XMax) && (blk_y_q == YMax);

endmodule

// File: rtl/me_frame_sequencer.sv
// Frame scheduler: walks macroblocks in raster order, starts the core, waits its latency
// and presents each captured motion vector on a valid/ready port.
module me_frame_sequencer
    import me_pkg::*;
#(
    parameter int unsigned BLOCKS_X  = 4,
    parameter int unsigned BLOCKS_Y  = 4,
    parameter int unsigned ME_CYCLES = ME_DEFAULT_CYCLES,
    parameter int unsigned CNT_W     = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_start,
    output logic                 busy,
    output logic                 me_start,
    output logic [BLK_IDX_W-1:0] blk_x,
    output logic [BLK_IDX_W-1:0] blk_y,
    input  logic [MV_W-1:0]      motionx,
    input  logic [MV_W-1:0]      motiony,
    output logic                 mv_valid,
    input  logic                 mv_ready,
    output logic [MV_W-1:0]      mv_x,
    output logic [MV_W-1:0]      mv_y,
    output logic [BLK_IDX_W-1:0] mv_bx,
    output logic [BLK_IDX_W-1:0] mv_by,
    output logic                 frame_done
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(ME_CYCLES - 1);

    me_seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MV_W-1:0]      mv_x_q, mv_y_q;
    logic [BLK_IDX_W-1:0] mv_bx_q, mv_by_q;
    logic                 capture;
    logic                 clear;
    logic                 advance;
    logic                 last;

    me_blk_walker #(
        .BLOCKS_X (BLOCKS_X),
        .BLOCKS_Y (BLOCKS_Y)
    ) u_walker (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .advance (advance),
        .blk_x   (blk_x),
        .blk_y   (blk_y),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        clear   = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    clear   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    capture = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (mv_ready) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = START;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mv_x_q  <= '0;
            mv_y_q  <= '0;
            mv_bx_q <= '0;
            mv_by_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                mv_x_q  <= motionx;
                mv_y_q  <= motiony;
                mv_bx_q <= blk_x;
                mv_by_q <= blk_y;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign me_start   = (state_q == START);
    assign mv_valid   = (state_q == PRESENT);
    assign frame_done = (state_q == DONE);
    assign mv_x       = mv_x_q;
    assign mv_y       = mv_y_q;
    assign mv_bx      = mv_bx_q;
    assign mv_by      = mv_by_q;

endmodule

// File: tb/tb_me_frame_sequencer.sv
// Scoreboard bench for me_frame_sequencer: three instances (2x2, 1x1, 3x1) with a stub core.
module tb_me_frame_sequencer;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] bx;
        logic [3:0] by;
    } vec_t;

    localparam int unsigned MeCyc = 8;
    localparam int unsigned Per   = MeCyc + 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: 2x2
    logic       fs_a, rdy_a, busy_a, st_a, val_a, done_a;
    logic [3:0] bx_a, by_a, mx_a, my_a, vx_a, vy_a, vbx_a, vby_a;
    assign mx_a = bx_a + 4'd1;
    assign my_a = 4'd15 - by_a;

    me_frame_sequencer #(.BLOCKS_X(2), .BLOCKS_Y(2), .ME_CYCLES(MeCyc), .CNT_W(4)) dut_a (
        .clock(clk), .reset(reset), .frame_start(fs_a), .busy(busy_a), .me_start(st_a),
        .blk_x(bx_a), .blk_y(by_a), .motionx(mx_a), .motiony(my_a), .mv_valid(val_a),
        .mv_ready(rdy_a), .mv_x(vx_a), .mv_y(vy_a), .mv_bx(vbx_a), .mv_by(vby_a),
        .frame_done(done_a)
    );

    // Instance b: 1x1
    logic       fs_b, rdy_b, busy_b, st_b, val_b, done_b;
    logic [3:0] bx_b, by_b, mx_b, my_b, vx_b, vy_b, vbx_b, vby_b;
    assign mx_b = bx_b + 4'd1;
    assign my_b = 4'd15 - by_b;

    me_frame_sequencer #(.BLOCKS_X(1), .BLOCKS_Y(1), .ME_CYCLES(MeCyc), .CNT_W(4)) dut_b (
        .clock(clk), .reset(reset), .frame_start(fs_b), .busy(busy_b), .me_start(st_b),
        .blk_x(bx_b), .blk_y(by_b), .motionx(mx_b), .motiony(my_b), .mv_valid(val_b),
        .mv_ready(rdy_b), .mv_x(vx_b), .mv_y(vy_b), .mv_bx(vbx_b), .mv_by(vby_b),
        .frame_done(done_b)
    );

    // Instance c: 3x1
    logic       fs_c, rdy_c, busy_c, st_c, val_c, done_c;
    logic [3:0] bx_c, by_c, mx_c, my_c, vx_c, vy_c, vbx_c, vby_c;
    assign mx_c = bx_c + 4'd1;
    assign my_c = 4'd15 - by_c;

    me_frame_sequencer #(.BLOCKS_X(3), .BLOCKS_Y(1), .ME_CYCLES(MeCyc), .CNT_W(4)) dut_c (
        .clock(clk), .reset(reset), .frame_start(fs_c), .busy(busy_c), .me_start(st_c),
        .blk_x(bx_c), .blk_y(by_c), .motionx(mx_c), .motiony(my_c), .mv_valid(val_c),
        .mv_ready(rdy_c), .mv_x(vx_c), .mv_y(vy_c), .mv_bx(vbx_c), .mv_by(vby_c),
        .frame_done(done_c)
    );

    vec_t exp_a[$], exp_b[$], exp_c[$];
    int   starts_a[$], dones_a[$], starts_c[$], blkx_c[$];
    bit   bad_c = 1'b0;
    bit   hold_a = 1'b0;
    vec_t prev_a;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t got, input vec_t want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d @(%0d,%0d), expected x=%0d y=%0d @(%0d,%0d)",
                     name, got.x, got.y, got.bx, got.by, want.x, want.y, want.bx, want.by);
        end
    endtask

    function automatic vec_t mk(input int bx, input int by);
        vec_t v;
        v.x  = 4'(bx + 1);
        v.y  = 4'(15 - by);
        v.bx = 4'(bx);
        v.by = 4'(by);
        return v;
    endfunction

    // Monitors: pop an expected vector on every accepted handshake.
    always @(negedge clk) begin
        if (!reset && val_a && rdy_a) begin
            if (exp_a.size() == 0) chk("a_unexpected_vec", 1, 0);
            else chk_vec("a_vec", {vx_a, vy_a, vbx_a, vby_a}, exp_a.pop_front());
        end
        if (!reset && val_b && rdy_b) begin
            if (exp_b.size() == 0) chk("b_unexpected_vec", 1, 0);
            else chk_vec("b_vec", {vx_b, vy_b, vbx_b, vby_b}, exp_b.pop_front());
        end
        if (!reset && val_c && rdy_c) begin
            if (exp_c.size() == 0) chk("c_unexpected_vec", 1, 0);
            else chk_vec("c_vec", {vx_c, vy_c, vbx_c, vby_c}, exp_c.pop_front());
        end
    end

    // Held vector must stay put while stalled.
    always @(negedge clk) begin
        if (hold_a && !reset) begin
            chk("a_hold_valid", int'(val_a), 1);
            chk_vec("a_hold_data", {vx_a, vy_a, vbx_a, vby_a}, prev_a);
        end
        hold_a = !reset && val_a && !rdy_a;
        prev_a = {vx_a, vy_a, vbx_a, vby_a};
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (st_a)   starts_a.push_back(cyc);
            if (done_a) dones_a.push_back(cyc);
            if (st_c) begin
                starts_c.push_back(cyc);
                blkx_c.push_back(int'(bx_c));
            end
            if (busy_c && by_c != 4'd0) bad_c = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int sel, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            step();
            case (sel)
                0:       seen = done_a;
                1:       seen = done_b;
                default: seen = done_c;
            endcase
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: frame_done not seen within 200 cycles, expected a pulse", name);
        end
    endtask

    task automatic clear_logs();
        starts_a.delete();
        dones_a.delete();
        starts_c.delete();
        blkx_c.delete();
    endtask

    initial begin
        int t0;
        int h;
        reset = 1'b1;
        fs_a = 0; rdy_a = 0; fs_b = 0; rdy_b = 0; fs_c = 0; rdy_c = 0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_outs", int'({st_a, val_a, done_a}), 0);
        chk("rst_data", int'({bx_a, by_a, vx_a, vy_a, vbx_a, vby_a}), 0);

        // 1: reset while searching block (1,0), counter at 3
        rdy_a = 1;
        exp_a.push_back(mk(0, 0));
        t0 = cyc;
        fs_a = 1;
        step();
        fs_a = 0;
        while (cyc < t0 + Per + 5) step();
        chk("t1_blk_before_rst", int'({bx_a, by_a}), 8'h10);
        chk("t1_busy_before_rst", int'(busy_a), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t1_busy_after_rst", int'(busy_a), 0);
        chk("t1_outs_after_rst", int'({st_a, val_a, done_a}), 0);
        chk("t1_data_after_rst", int'({bx_a, by_a, vx_a, vy_a, vbx_a, vby_a}), 0);
        chk("t1_vec_delivered", exp_a.size(), 0);
        step();
        chk("t1_no_start_after_rst", int'(st_a), 0);

        // 2: 2x2 frame, ready tied high
        clear_logs();
        for (int by = 0; by < 2; by++)
            for (int bx = 0; bx < 2; bx++) exp_a.push_back(mk(bx, by));
        t0 = cyc;
        fs_a = 1;
        step();
        fs_a = 0;
        wait_done(0, "t2_done");
        step();
        chk("t2_busy_low", int'(busy_a), 0);
        chk("t2_idle_cycle", cyc, t0 + 4 * Per + 2);
        chk("t2_nstarts", starts_a.size(), 4);
        for (int i = 0; i < 4 && i < starts_a.size(); i++)
            chk("t2_start_cyc", starts_a[i], t0 + 1 + Per * i);
        chk("t2_ndone", dones_a.size(), 1);
        if (dones_a.size() > 0) chk("t2_done_cyc", dones_a[0], t0 + 4 * Per + 1);
        chk("t2_vecs_left", exp_a.size(), 0);

        // 3: backpressure on the first vector
        clear_logs();
        rdy_a = 0;
        for (int by = 0; by < 2; by++)
            for (int bx = 0; bx < 2; bx++) exp_a.push_back(mk(bx, by));
        t0 = cyc;
        fs_a = 1;
        step();
        fs_a = 0;
        for (int k = 0; k < 40 && !val_a; k++) step();
        chk("t3_first_valid_cyc", cyc, t0 + 2 + MeCyc);
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid_held", int'(val_a), 1);
            step();
        end
        rdy_a = 1;
        h = cyc;
        wait_done(0, "t3_done");
        chk("t3_nstarts", starts_a.size(), 4);
        if (starts_a.size() > 1) chk("t3_restart_cyc", starts_a[1], h + 1);
        if (dones_a.size() > 0) chk("t3_done_cyc", dones_a[0], h + 3 * Per + 1);
        chk("t3_vecs_left", exp_a.size(), 0);

        // 4: frame_start during RUN and PRESENT is ignored
        step();
        clear_logs();
        for (int by = 0; by < 2; by++)
            for (int bx = 0; bx < 2; bx++) exp_a.push_back(mk(bx, by));
        t0 = cyc;
        fs_a = 1;
        step();
        fs_a = 0;
        while (cyc < t0 + 5) step();
        fs_a = 1;
        step();
        fs_a = 0;
        while (cyc < t0 + 2 + MeCyc) step();
        chk("t4_in_present", int'(val_a), 1);
        fs_a = 1;
        step();
        fs_a = 0;
        wait_done(0, "t4_done");
        repeat (20) step();
        chk("t4_nstarts", starts_a.size(), 4);
        chk("t4_ndone", dones_a.size(), 1);
        chk("t4_idle", int'(busy_a), 0);
        chk("t4_vecs_left", exp_a.size(), 0);

        // 5: 1x1 frame
        rdy_b = 1;
        exp_b.push_back(mk(0, 0));
        t0 = cyc;
        fs_b = 1;
        step();
        fs_b = 0;
        wait_done(1, "t5_done");
        chk("t5_done_cyc", cyc, t0 + Per + 1);
        chk("t5_vecs_left", exp_b.size(), 0);
        step();
        chk("t5_idle", int'(busy_b), 0);

        // 6: 3x1 frame, no wrap into row 1
        rdy_c = 1;
        for (int bx = 0; bx < 3; bx++) exp_c.push_back(mk(bx, 0));
        t0 = cyc;
        fs_c = 1;
        step();
        fs_c = 0;
        wait_done(2, "t6_done");
        chk("t6_done_cyc", cyc, t0 + 3 * Per + 1);
        chk("t6_nstarts", blkx_c.size(), 3);
        for (int i = 0; i < 3 && i < blkx_c.size(); i++) chk("t6_blk_x", blkx_c[i], i);
        chk("t6_row_stays_0", int'(bad_c), 0);
        chk("t6_vecs_left", exp_c.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
